// File: rtl/alu_bist_ctrl.sv
// Self-test sequencer for the 8-bit alu: LFSR operands, all 8 opcodes per vector, golden-model compare.
// Optional result MISR on `signature` is built only when ALU_BIST_SIG_EN is defined.
module alu_bist_ctrl #(
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [7:0]  alu_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic        first_fail_valid,
  output logic [2:0]  first_fail_op,
  output logic [7:0]  first_fail_vec,
  output logic [15:0] signature
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // An all-zero seed would lock the LFSR, so it is remapped.
  localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  LAST_VEC    = 8'(NUM_VECTORS - 1);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = {a[6:0], 1'b0};
      3'd6:    r = {1'b0, a[7:1]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [2:0]  state;
  logic [3:0]  settle_cnt;
  logic [2:0]  op;
  logic [7:0]  vec;
  logic [15:0] lfsr;
  logic [7:0]  expected;
  logic        mismatch;
  logic        start_acc;
  logic        check_cnt;

  // Golden value comes from the registered operands, i.e. exactly what the alu sees.
  always_comb begin
    expected  = golden(alu_a, alu_b, alu_ctrl);
    mismatch  = (alu_result != expected);
    start_acc = (state == S_IDLE) && start;
    check_cnt = (state == S_CHECK) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      settle_cnt       <= 4'd0;
      op               <= 3'd0;
      vec              <= 8'd0;
      lfsr             <= 16'h0000;
      alu_a            <= 8'h00;
      alu_b            <= 8'h00;
      alu_ctrl         <= 3'b111;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 8'd0;
      first_fail_valid <= 1'b0;
      first_fail_op    <= 3'd0;
      first_fail_vec   <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_APPLY;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_count        <= 8'd0;
            first_fail_valid <= 1'b0;
            first_fail_op    <= 3'd0;
            first_fail_vec   <= 8'd0;
            lfsr             <= SEED_EFF;
            op               <= 3'd0;
            vec              <= 8'd0;
          end
        end
        S_APPLY: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            alu_a      <= lfsr[15:8];
            alu_b      <= lfsr[7:0];
            alu_ctrl   <= op;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt == 4'd0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          // Abort wins over the compare: the sample in flight is discarded.
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (mismatch) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_op    <= op;
                first_fail_vec   <= vec;
              end
            end
            if (op == 3'd7 && vec == LAST_VEC) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              state <= S_APPLY;
              op    <= op + 3'd1;
              if (op == 3'd7) begin
                vec  <= vec + 8'd1;
                lfsr <= lfsr_step(lfsr);
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == 8'd0);
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_BIST_SIG_EN
  logic [15:0] sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= 16'h0000;
    end else if (start_acc) begin
      sig <= 16'h0000;
    end else if (check_cnt) begin
      sig <= lfsr_step(sig) ^ {8'h00, alu_result};
    end
  end

  assign signature = sig;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Scoreboard bench for alu_bist_ctrl: behavioural alu with fault modes, operand and end-of-run monitors.
module tb_alu_bist_ctrl;

  typedef struct {
    int         lat;
    logic       pass;
    logic [7:0] err;
    logic       ffv;
    logic [2:0] ffop;
    logic [7:0] ffvec;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [7:0]  alu_a, alu_b, alu_result, err_count, first_fail_vec;
  logic [2:0]  alu_ctrl, first_fail_op;
  logic        busy, done, pass, first_fail_valid;
  logic [15:0] signature;

  logic        sat_start, sat_abort;
  logic [7:0]  sat_a, sat_b, sat_err, sat_ffvec;
  logic [2:0]  sat_ctrl, sat_ffop;
  logic        sat_busy, sat_done, sat_pass, sat_ffv;
  logic [15:0] sat_sig;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   k_main, k_sat;
  int   fault_mode;
  bit   track_ops;
  exp_t run_q[$];
  exp_t sat_q[$];
  logic [18:0] op_q[$];
  logic [7:0] va[4] = '{8'hAC, 8'h59, 8'hB3, 8'h67};
  logic [7:0] vb[4] = '{8'hE1, 8'hC3, 8'h87, 8'h0F};
  logic        busy_d1 = 1'b0, busy_d2 = 1'b0;
  logic [2:0]  ctrl_d1 = 3'd0;
  logic [15:0] sig_a, sig_b, sig_tmp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_bist_ctrl #(.NUM_VECTORS(4), .SETTLE_CYCLES(1), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_op(first_fail_op),
    .first_fail_vec(first_fail_vec), .signature(signature)
  );

  alu_bist_ctrl #(.NUM_VECTORS(64), .SETTLE_CYCLES(1), .SEED(16'hACE1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(sat_start), .abort(sat_abort),
    .alu_a(sat_a), .alu_b(sat_b), .alu_ctrl(sat_ctrl), .alu_result(8'h00),
    .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_count(sat_err),
    .first_fail_valid(sat_ffv), .first_fail_op(sat_ffop),
    .first_fail_vec(sat_ffvec), .signature(sat_sig)
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << 1;
      3'd6: return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  // Mode 1: stuck-at-zero alu. Mode 2: bit 0 flipped on OR when A = B3 (vector 2).
  always_comb begin
    alu_result = alu_model(alu_a, alu_b, alu_ctrl);
    if (fault_mode == 1) alu_result = 8'h00;
    else if (fault_mode == 2 && alu_ctrl == 3'd3 && alu_a == 8'hB3) alu_result = alu_result ^ 8'h01;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Operand monitor: one sample per opcode, taken once the new operands are on the bus.
  always @(negedge clk) begin
    if (track_ops && busy && busy_d1 && (!busy_d2 || alu_ctrl != ctrl_d1)) begin
      if (op_q.size() == 0) check("ops_unexpected", {alu_a, alu_b, 5'd0, alu_ctrl}, 0);
      else check("operands", {13'd0, alu_a, alu_b, alu_ctrl}, {13'd0, op_q.pop_front()});
    end
    busy_d2 <= busy_d1;
    busy_d1 <= busy;
    ctrl_d1 <= alu_ctrl;
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (run_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = run_q.pop_front();
        check("done_latency", cyc - k_main, e.lat);
        check("done_busy", busy, 0);
        check("pass", pass, e.pass);
        check("err_count", err_count, e.err);
        check("ff_valid", first_fail_valid, e.ffv);
        check("ff_op", first_fail_op, e.ffop);
        check("ff_vec", first_fail_vec, e.ffvec);
`ifndef ALU_BIST_SIG_EN
        check("signature_off", signature, 0);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sat_done) begin
      if (sat_q.size() == 0) check("sat_done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sat_q.pop_front();
        check("sat_latency", cyc - k_sat, e.lat);
        check("sat_pass", sat_pass, e.pass);
        check("sat_err_count", sat_err, e.err);
        check("sat_ff_valid", sat_ffv, e.ffv);
        check("sat_ff_op", sat_ffop, e.ffop);
        check("sat_ff_vec", sat_ffvec, e.ffvec);
      end
    end
  end

  task automatic kick(input int hold);
    @(negedge clk);
    start  = 1'b1;
    k_main = cyc + 1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input int mode, input exp_t e, input int hold, output logic [15:0] sig);
    int t = 0;
    fault_mode = mode;
    track_ops  = 1'b1;
    for (int v = 0; v < 4; v++)
      for (int o = 0; o < 8; o++) op_q.push_back({va[v], vb[v], 3'(o)});
    run_q.push_back(e);
    kick(hold);
    while (!done && t < 3000) begin @(negedge clk); t++; end
    if (!done) begin
      check("done_timeout", 0, 1);
      run_q.delete();
    end
    repeat (3) @(negedge clk);
    sig = signature;
    check("ops_left", op_q.size(), 0);
    op_q.delete();
    track_ops = 1'b0;
  endtask

  task automatic abort_at(input int mode, input int off, input int exp_err, input int exp_ffv);
    fault_mode = mode;
    kick(1);
    while (cyc < k_main + off - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_err", err_count, exp_err);
    check("abort_ffv", first_fail_valid, exp_ffv);
    check("abort_pass", pass, 0);
    repeat (4) @(negedge clk);
    check("abort_stays_idle", busy, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_ffv"}, first_fail_valid, 0);
    check({tag, "_ffop"}, first_fail_op, 0);
    check({tag, "_ffvec"}, first_fail_vec, 0);
    check({tag, "_a"}, alu_a, 0);
    check({tag, "_b"}, alu_b, 0);
    check({tag, "_ctrl"}, alu_ctrl, 3'b111);
    check({tag, "_sig"}, signature, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sat_start = 1'b0; sat_abort = 1'b0;
    fault_mode = 0; track_ops = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_run(0, '{97, 1'b1, 8'd0, 1'b0, 3'd0, 8'd0}, 1, sig_a);
    abort_at(0, 10, 0, 0);
    do_run(0, '{97, 1'b1, 8'd0, 1'b0, 3'd0, 8'd0}, 1, sig_b);
`ifdef ALU_BIST_SIG_EN
    check("sig_repeat", sig_b, sig_a);
    check("sig_nonzero", sig_a != 16'h0000, 1);
`endif
    do_run(1, '{97, 1'b0, 8'd28, 1'b1, 3'd0, 8'd0}, 1, sig_tmp);
    do_run(2, '{97, 1'b0, 8'd1, 1'b1, 3'd3, 8'd2}, 1, sig_tmp);
    abort_at(1, 3, 0, 0);
    abort_at(1, 6, 1, 1);

    // Reset asserted while op 2 is settling, after two counted errors.
    fault_mode = 1;
    kick(1);
    while (cyc < k_main + 7) @(negedge clk);
    check("pre_reset_err", err_count, 2);
    rst_n = 1'b0;
    #1;
    check_reset("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_run(0, '{97, 1'b1, 8'd0, 1'b0, 3'd0, 8'd0}, 50, sig_tmp);

    sat_q.push_back('{1537, 1'b0, 8'd255, 1'b1, 3'd0, 8'd0});
    @(negedge clk);
    sat_start = 1'b1;
    k_sat = cyc + 1;
    @(negedge clk);
    sat_start = 1'b0;
    t = 0;
    while (!sat_done && t < 2000) begin @(negedge clk); t++; end
    if (!sat_done) check("sat_timeout", 0, 1);
    repeat (3) @(negedge clk);

    check("run_q_empty", run_q.size(), 0);
    check("sat_q_empty", sat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist_ctrl.md
# alu_bist_ctrl

Synthesizable built-in self-test controller for the 8-bit `alu`. It drives `A`/`B`/`ALUControl` from an LFSR operand source and samples `Result` after a programmable settle time. Each sample is compared against an internal golden model, and the block reports error count, first failure and pass/fail. It is the on-chip replacement for bench-driven stimulus and sits beside `alu` in the top level, connected directly to its ports.

## Interface

Parameters:
- `NUM_VECTORS`, default 16: operand pairs per run (1..255); each pair is applied to all 8 opcodes.
- `SETTLE_CYCLES`, default 1: cycles between driving operands and sampling `Result` (1..15).
- `SEED`, default 16'hACE1: LFSR seed; a value of 0 is replaced by 16'h0001.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  synchronous abort of a run.
- `alu_a`  out  8  drives `alu.A`.
- `alu_b`  out  8  drives `alu.B`.
- `alu_ctrl`  out  3  drives `alu.ALUControl`.
- `alu_result`  in  8  from `alu.Result`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a completed run.
- `pass`  out  1  last completed run had zero errors.
- `err_count`  out  8  mismatches, saturating at 255.
- `first_fail_valid`  out  1  at least one mismatch has occurred in this run.
- `first_fail_op`  out  3  opcode of the first mismatch.
- `first_fail_vec`  out  8  vector index of the first mismatch.
- `signature`  out  16  result MISR; see Configuration.

## Operation

- **Golden model** (8-bit, results truncated):
  - 000 A+B; 001 A−B (two's complement); 010 A&B; 011 A|B; 100 A^B.
  - 101 A<<1, logical; 110 A>>1, logical; 111 8'h00.
- **Operand source:**
  - 16-bit Fibonacci LFSR, shift left, feedback bit = l[15]^l[13]^l[12]^l[10].
  - `A` = l[15:8], `B` = l[7:0].
  - The LFSR loads `SEED` on start and advances once after opcode 7 of each vector.
- **Run order:** for vec = 0..NUM_VECTORS−1, apply op = 0..7.
- **FSM states:** IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE: `start` = 1 → APPLY. On this transition:
    - err_count, first_fail_*, signature and pass are cleared;
    - the LFSR loads `SEED`;
    - vec and op are set to 0.
  - APPLY (1 cycle): registers `alu_a`, `alu_b` and `alu_ctrl` = op. → SETTLE.
  - SETTLE (SETTLE_CYCLES cycles, down-counter) → CHECK.
  - CHECK (1 cycle): compares `alu_result` with the golden value computed from the registered outputs.
    - On mismatch: err_count += 1, saturating at 255. If first_fail_valid = 0, capture op and vec and set first_fail_valid.
    - Signature update happens here.
    - If op = 7 and vec = NUM_VECTORS−1 → DONE; otherwise advance op/vec (and the LFSR after op 7) → APPLY.
  - DONE (1 cycle): `done` = 1, `pass` ← (err_count == 0). → IDLE.
- `abort` = 1 in APPLY, SETTLE or CHECK → IDLE next cycle.
  - No `done` pulse; `pass` stays 0.
  - Counters hold their partial values.
- `abort` has priority over CHECK's comparison in the same cycle, so that sample is not counted.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: start wins and abort is ignored.
- `busy` = 1 in APPLY, SETTLE and CHECK.
- Reset values of all outputs:
  - busy = 0, done = 0, pass = 0, err_count = 0;
  - first_fail_valid = 0, first_fail_op = 0, first_fail_vec = 0;
  - alu_a = 0, alu_b = 0, alu_ctrl = 3'b111, signature = 0;
  - state = IDLE.
- Asserting `rst_n` low mid-run forces the reset values immediately.

## Timing

- All outputs are registered.
- Each opcode takes SETTLE_CYCLES + 2 cycles.
- `start` is sampled high at edge k. `busy` rises after edge k. `done` is high for the cycle after edge k + 1 + 8·NUM_VECTORS·(SETTLE_CYCLES+2).
- `pass`, `err_count` and `first_fail_*` are stable from the `done` cycle until the next accepted start.
- `alu_a`, `alu_b` and `alu_ctrl` are held constant from APPLY through CHECK.

## Configuration

- `ALU_BIST_SIG_EN` defined:
  - `signature` is a 16-bit MISR updated in every counted CHECK: sig ← {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {8'h00, alu_result}.
  - It is cleared on start.
- `ALU_BIST_SIG_EN` undefined: `signature` is tied to 16'h0000 and no MISR logic is built.

## Test plan

- **Correct ALU, first vector:** NUM_VECTORS = 1, SETTLE_CYCLES = 1, SEED = 16'hACE1.
  - Samples per op 0..7 = 8D, CB, A0, ED, 4D, 58, 56, 00.
  - `done` is high 25 cycles after the start edge; pass = 1; err_count = 0.
- **Full run:** NUM_VECTORS = 4, SETTLE_CYCLES = 1, correct ALU → done at start edge + 97 cycles, pass = 1, first_fail_valid = 0.
- **Faulty ALU, constant zero:** `alu_result` forced to 8'h00, NUM_VECTORS = 1, SEED = 16'hACE1 → err_count = 7, first_fail_op = 0, first_fail_vec = 0, pass = 0.
- **Abort:** `abort` asserted at start edge + 10 → busy = 0 next cycle, no done pulse, pass = 0. A new start then runs to completion with pass = 1.
- **Reset mid-run:** `rst_n` low during SETTLE → immediately busy = 0, alu_ctrl = 3'b111, err_count = 0, signature = 0. `start` held high while busy has no effect on the done cycle.
- **Saturation and signature:** ALU forced to 8'h00 with NUM_VECTORS = 64 → err_count = 255.
  - With `ALU_BIST_SIG_EN` defined, two identical correct runs give an identical non-zero signature.
  - Without the macro, signature = 0.
